// File: rtl/fetch_request_queue.sv
// fetch_request_queue
//   Fetch request queue between the fetch unit / instruction memory and the
//   decoder. An entry is allocated when a request issues (address plus
//   prediction flags). It is filled when the instruction returns, in request
//   order. Only filled entries are shown to decode. Requests still in flight
//   when a flush happens are counted, and their late returns are dropped.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   flush_i                 discard all entries, mark in-flight requests stale
//   alloc_i, alloc_*_i      request issue: address, speculative, taken
//   fill_i, fill_instruction_i  instruction return (in request order)
//   read_i                  decoder pops the head entry
//   valid_o                 head entry allocated and filled
//   instruction_o           head instruction, NOP_WORD when !valid_o
//   address_o, speculative_o, taken_o  head entry fields
//   count_o, empty_o, full_o, almost_full_o  registered occupancy status
//   fill_error_o            one-cycle pulse after a fill with nothing outstanding
module fetch_request_queue #(
    parameter int              DEPTH          = 8,
    parameter int              XLEN           = 32,
    parameter int              ALMOST_FULL_TH = 6,
    parameter logic [XLEN-1:0] NOP_WORD       = 32'h00000013
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_address_i,
    input  logic                       alloc_speculative_i,
    input  logic                       alloc_taken_i,
    input  logic                       fill_i,
    input  logic [XLEN-1:0]            fill_instruction_i,
    input  logic                       read_i,
    output logic                       valid_o,
    output logic [XLEN-1:0]            instruction_o,
    output logic [XLEN-1:0]            address_o,
    output logic                       speculative_o,
    output logic                       taken_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       fill_error_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t alloc_ptr_q, fill_ptr_q, read_ptr_q, drop_cnt_q;
    ptr_t alloc_ptr_d, fill_ptr_d, read_ptr_d, drop_cnt_d;
    ptr_t count_q, count_d;
    logic empty_q, full_q, afull_q, fill_err_q, fill_err_d;

    logic [XLEN-1:0] addr_mem  [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic            spec_mem  [DEPTH];
    logic            taken_mem [DEPTH];

    logic          alloc_we, fill_we;
    logic [IW-1:0] alloc_idx;
    ptr_t          drop_sum;

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        read_ptr_d  = read_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        fill_err_d  = 1'b0;
        alloc_we    = 1'b0;
        fill_we     = 1'b0;
        alloc_idx   = alloc_ptr_q[IW-1:0];
        drop_sum    = '0;

        if (flush_i) begin
            // Requests not yet filled become stale returns. A fill arriving in
            // the flush cycle consumes one of them.
            drop_sum = (alloc_ptr_q - fill_ptr_q) + drop_cnt_q;
            if (fill_i && drop_sum != '0)
                drop_sum = drop_sum - PW'(1);
            drop_cnt_d = drop_sum;
            read_ptr_d = '0;
            fill_ptr_d = '0;
            if (alloc_i) begin
                alloc_we    = 1'b1;
                alloc_idx   = '0;
                alloc_ptr_d = PW'(1);
            end else begin
                alloc_ptr_d = '0;
            end
        end else begin
            if (alloc_i && !full_q) begin
                alloc_we    = 1'b1;
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (fill_i) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - PW'(1);
                end else if (fill_ptr_q != alloc_ptr_q) begin
                    fill_we    = 1'b1;
                    fill_ptr_d = fill_ptr_q + PW'(1);
                end else begin
                    fill_err_d = 1'b1;
                end
            end
            if (read_i && valid_o)
                read_ptr_d = read_ptr_q + PW'(1);
        end

        count_d = alloc_ptr_d - read_ptr_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            read_ptr_q  <= '0;
            drop_cnt_q  <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            read_ptr_q  <= read_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == PW'(DEPTH));
            afull_q     <= (count_d >= PW'(ALMOST_FULL_TH));
            fill_err_q  <= fill_err_d;
        end
    end

    // Storage is cleared on reset so the head fields read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_mem  <= '{default: '0};
            instr_mem <= '{default: '0};
            spec_mem  <= '{default: 1'b0};
            taken_mem <= '{default: 1'b0};
        end else begin
            if (alloc_we) begin
                addr_mem[alloc_idx]  <= alloc_address_i;
                spec_mem[alloc_idx]  <= alloc_speculative_i;
                taken_mem[alloc_idx] <= alloc_taken_i;
            end
            if (fill_we)
                instr_mem[fill_ptr_q[IW-1:0]] <= fill_instruction_i;
        end
    end

    always_comb begin
        valid_o       = (fill_ptr_q != read_ptr_q);
        instruction_o = valid_o ? instr_mem[read_ptr_q[IW-1:0]] : NOP_WORD;
        address_o     = addr_mem[read_ptr_q[IW-1:0]];
        speculative_o = spec_mem[read_ptr_q[IW-1:0]];
        taken_o       = taken_mem[read_ptr_q[IW-1:0]];
        count_o       = count_q;
        empty_o       = empty_q;
        full_o        = full_q;
        almost_full_o = afull_q;
        fill_error_o  = fill_err_q;
    end

endmodule

// File: tb/tb_fetch_request_queue.sv
// tb_fetch_request_queue
//   Self-checking bench for fetch_request_queue (DEPTH=8, XLEN=32, TH=6).
//   A queue-based reference model tracks entries, the filled prefix and the
//   number of stale returns still to be dropped.
module tb_fetch_request_queue;

    localparam int DEPTH = 8;
    localparam int TH    = 6;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0, alloc_i = 1'b0, fill_i = 1'b0, read_i = 1'b0;
    logic [31:0] alloc_address_i = '0, fill_instruction_i = '0;
    logic        alloc_speculative_i = 1'b0, alloc_taken_i = 1'b0;
    logic        valid_o, speculative_o, taken_o;
    logic [31:0] instruction_o, address_o;
    logic [3:0]  count_o;
    logic        empty_o, full_o, almost_full_o, fill_error_o;

    fetch_request_queue #(.DEPTH(DEPTH), .XLEN(32), .ALMOST_FULL_TH(TH),
                          .NOP_WORD(NOP)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .alloc_i(alloc_i), .alloc_address_i(alloc_address_i),
        .alloc_speculative_i(alloc_speculative_i), .alloc_taken_i(alloc_taken_i),
        .fill_i(fill_i), .fill_instruction_i(fill_instruction_i),
        .read_i(read_i), .valid_o(valid_o), .instruction_o(instruction_o),
        .address_o(address_o), .speculative_o(speculative_o),
        .taken_o(taken_o), .count_o(count_o), .empty_o(empty_o),
        .full_o(full_o), .almost_full_o(almost_full_o),
        .fill_error_o(fill_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        spec;
        logic        taken;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int   filled = 0;
    int   drop   = 0;
    bit   exp_err = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        filled  = 0;
        drop    = 0;
        exp_err = 1'b0;
    endtask

    task automatic model_step(input bit f, input bit a, input logic [31:0] ad,
                              input bit sp, input bit tk, input bit fl,
                              input logic [31:0] ins, input bit rd);
        ent_t e;
        int   stale;
        bit   was_full, was_valid;
        e.addr = ad; e.spec = sp; e.taken = tk; e.instr = '0;
        exp_err = 1'b0;
        if (f) begin
            stale = (q.size() - filled) + drop - (fl ? 1 : 0);
            drop  = (stale < 0) ? 0 : stale;
            q.delete();
            filled = 0;
            if (a) q.push_back(e);
        end else begin
            was_full  = (q.size() == DEPTH);
            was_valid = (filled > 0);
            if (fl) begin
                if (drop > 0) drop--;
                else if (filled < q.size()) begin
                    q[filled].instr = ins;
                    filled++;
                end else exp_err = 1'b1;
            end
            if (rd && was_valid) begin
                void'(q.pop_front());
                filled--;
            end
            if (a && !was_full) q.push_back(e);
        end
    endtask

    task automatic check_all();
        check_val("valid", 32'(valid_o), 32'(filled > 0));
        check_val("instruction", instruction_o, (filled > 0) ? q[0].instr : NOP);
        check_val("count", 32'(count_o), 32'(q.size()));
        check_val("empty", 32'(empty_o), 32'(q.size() == 0));
        check_val("full", 32'(full_o), 32'(q.size() == DEPTH));
        check_val("almost_full", 32'(almost_full_o), 32'(q.size() >= TH));
        check_val("fill_error", 32'(fill_error_o), 32'(exp_err));
        if (q.size() > 0) begin
            check_val("address", address_o, q[0].addr);
            check_val("speculative", 32'(speculative_o), 32'(q[0].spec));
            check_val("taken", 32'(taken_o), 32'(q[0].taken));
        end
    endtask

    // Called at a negative edge: drive, clock, update model, check.
    task automatic step(input bit f, input bit a, input logic [31:0] ad,
                        input bit sp, input bit tk, input bit fl,
                        input logic [31:0] ins, input bit rd);
        flush_i = f; alloc_i = a; alloc_address_i = ad;
        alloc_speculative_i = sp; alloc_taken_i = tk;
        fill_i = fl; fill_instruction_i = ins; read_i = rd;
        @(posedge clk_i);
        #1;
        model_step(f, a, ad, sp, tk, fl, ins, rd);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        bit f, a, fl, rd;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all();
        check_val("rst_addr", address_o, 32'h0);
        check_val("rst_empty", 32'(empty_o), 32'h1);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Two unfilled allocs.
        step(0, 1, 32'h100, 0, 0, 0, '0, 0);
        step(0, 1, 32'h104, 1, 1, 0, '0, 0);
        check_val("two_alloc_count", 32'(count_o), 32'd2);
        check_val("two_alloc_nop", instruction_o, 32'h00000013);
        step(0, 0, '0, 0, 0, 1, 32'h00500093, 0);
        check_val("first_fill_instr", instruction_o, 32'h00500093);
        check_val("first_fill_addr", address_o, 32'h100);
        step(0, 0, '0, 0, 0, 0, '0, 1);
        check_val("after_read_count", 32'(count_o), 32'd1);
        check_val("after_read_valid", 32'(valid_o), 32'd0);
        step(0, 0, '0, 0, 0, 1, 32'h11111111, 0);
        step(0, 0, '0, 0, 0, 0, '0, 1);

        // Fill to full, then a blocked alloc with a simultaneous read.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 32'h1000 + 32'(i * 4), i[0], i[1], 0, '0, 0);
            if (i == TH - 2) check_val("afull_before_th", 32'(almost_full_o), 32'd0);
            if (i == TH - 1) check_val("afull_at_th", 32'(almost_full_o), 32'd1);
        end
        check_val("full_set", 32'(full_o), 32'd1);
        step(0, 0, '0, 0, 0, 1, 32'hAAAA0001, 0);
        step(0, 1, 32'hDEAD, 0, 0, 0, '0, 1);
        check_val("blocked_alloc_count", 32'(count_o), 32'd7);
        check_val("blocked_alloc_full", 32'(full_o), 32'd0);

        // Flush with 7 outstanding, drain the stale returns.
        step(1, 0, '0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 0, 0, 1, 32'hBAD0 + 32'(i), 0);

        // 3 unfilled, flush with alloc 0x200; 3 stale returns then the real one.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h300 + 32'(i), 0, 0, 0, '0, 0);
        step(1, 1, 32'h200, 1, 0, 0, '0, 0);
        check_val("flush_alloc_count", 32'(count_o), 32'd1);
        check_val("flush_alloc_empty", 32'(empty_o), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 1, 32'hBAD1, 0);
        step(0, 0, '0, 0, 0, 1, 32'h00000073, 0);
        check_val("post_flush_instr", instruction_o, 32'h00000073);
        check_val("post_flush_addr", address_o, 32'h200);
        step(0, 0, '0, 0, 0, 0, '0, 1);

        // Flush with fill and 2 outstanding: one stale left, then an error fill.
        step(0, 1, 32'h400, 0, 0, 0, '0, 0);
        step(0, 1, 32'h404, 0, 0, 0, '0, 0);
        step(1, 0, '0, 0, 0, 1, 32'hBAD2, 0);
        step(0, 0, '0, 0, 0, 1, 32'hBAD3, 0);
        check_val("stale_no_error", 32'(fill_error_o), 32'd0);
        step(0, 0, '0, 0, 0, 1, 32'hBAD4, 0);
        check_val("unexpected_fill_err", 32'(fill_error_o), 32'd1);
        check_val("unexpected_fill_count", 32'(count_o), 32'd0);
        idle();
        check_val("err_pulse_one_cycle", 32'(fill_error_o), 32'd0);

        // Pointer wrap with steady alloc/fill/read triples.
        step(0, 1, 32'h5000, 0, 0, 0, '0, 0);
        step(0, 1, 32'h5004, 0, 0, 1, 32'h7000, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 32'h5008 + 32'(i * 4), 0, 1, 1, 32'h7004 + 32'(i), 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 1, 32'h8000 + 32'(i), 1);

        // Randomised traffic with an occasional mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            f  = ($urandom_range(0, 19) == 0);
            a  = ($urandom_range(0, 99) < 55);
            fl = ($urandom_range(0, 99) < 45);
            rd = ($urandom_range(0, 99) < 50);
            if (f && (drop + q.size() - filled) >= DEPTH) f = 1'b0;
            if (f && (drop + q.size() - filled) == 0) fl = 1'b0;
            if (c == 1500) begin
                rst_n_i = 1'b0;
                #2;
                model_reset();
                check_all();
                @(negedge clk_i);
                rst_n_i = 1'b1;
            end
            step(f, a, $urandom, 1'($urandom), 1'($urandom), fl, $urandom, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
